bcd_down_counter_12b: RTL and testbench
=======================================

Name: bcd_down_counter_12b

Overview:
- Loadable 3-digit (12-bit) packed-BCD countdown counter with start/pause control and a terminal-count pulse.
- It is the decrement-direction counterpart of the team's BCD incrementor chain. It drives countdown timers and seven-segment displays.
- Ticks come from an external enable strobe (for example a 1 Hz or 1 kHz pulse), not from the clock directly.

Parameters:
- AUTO_RELOAD, 0: when 1, reaching 000 reloads the last loaded value and keeps running. When 0, the counter stops at 000.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  1-cycle strobe; capture load_val
- load_val  in  12  packed BCD value, 3 digits; [3:0] is ones
- start  in  1  1-cycle strobe; begin counting
- pause  in  1  level; while high in RUN, ticks are ignored
- tick  in  1  1-cycle decrement enable
- count  out  12  current packed BCD value
- busy  out  1  high while in RUN
- done  out  1  1-cycle pulse when count reaches 000 from a tick
- zero  out  1  combinational: count == 12'h000
- load_err  out  1  1-cycle pulse; load_val held a digit > 9

Behaviour:
- Reset: count=000, reload register=000, state IDLE, busy=0, done=0, load_err=0, so zero=1. Reset overrides all other inputs.
- States:
  - IDLE: count holds.
  - RUN: ticks decrement the count.
- Priority within a cycle: reset > load > start > tick.
- load, accepted in any state:
  - Next edge: count and reload register take the sanitised load_val, state goes to IDLE, done=0.
  - Any digit > 9 is clamped to 9, and load_err pulses for 1 cycle (example: 0x1F3 loads 0x193).
  - A load in RUN aborts the run.
- start in IDLE:
  - count != 000: go to RUN; busy=1 from the next cycle.
  - count == 000: stay in IDLE, no done pulse.
  - start in RUN is ignored.
- RUN, tick=1, pause=0: count decrements by one in BCD at the next edge.
  - Per digit: a digit that is 0 wraps to 9 and borrows from the next digit. Otherwise it decrements and no borrow propagates.
  - Borrow out of digit 2 cannot occur, because 000 is never decremented.
  - Latency: 1 clk from tick to updated count.
- Terminal, on a tick with count == 001:
  - The same edge sets count=000 and done=1 for exactly one cycle.
  - AUTO_RELOAD=0: state goes to IDLE, busy=0 in the same cycle that done=1.
  - AUTO_RELOAD=1: the next qualifying tick loads the reload register (instead of decrementing) and the counter stays in RUN. If the reload value is 000, state goes to IDLE.
- Ticks in IDLE, or in RUN with pause=1, have no effect. pause does not change state.
- tick asserted on consecutive cycles: each cycle decrements. There is no edge detection on tick.
- All outputs except zero are registered. zero is decoded from the count register.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W=4, BCD_DIGITS=3, BCD_MAX_DIGIT=4'd9.
  - The state encoding (IDLE=1'b0, RUN=1'b1).
  - A digit-clamp function.
- Sub-module bcd_decrementor (in[3:0], en, borrow, out[3:0]): one combinational digit stage, chained with en/borrow exactly like the incrementor chain.
  - When en=0: out=in, borrow=0.
  - When en=1: in=0 gives out=9, borrow=1; otherwise out=in-1, borrow=0.
- Top level instantiates three bcd_decrementor stages, the FSM, and the reload and output registers.

Test Plan:
- Reset, then load 0x123 and start, then 3 ticks -> count 0x122, 0x121, 0x120; busy=1; done=0.
- Load 0x100, start, 1 tick -> count 0x099 (double borrow); zero=0.
- Load 0x002, start, 2 ticks with AUTO_RELOAD=0 -> count 0x001 then 0x000 with done=1 for one cycle, busy=0, zero=1; a further tick keeps count 0x000 and no done pulse.
- AUTO_RELOAD=1, load 0x001, start, 3 ticks -> count 0x000 (done pulse), 0x001, 0x000 (second done pulse); busy stays 1.
- Load 0x5A9 -> count 0x599 and load_err pulses 1 cycle. In RUN with pause=1, 4 ticks -> count unchanged at 0x599.
- Load and start in the same cycle as a tick -> load wins: count = load_val, state IDLE. Reset asserted mid-RUN -> next cycle count 0x000, busy=0, zero=1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit sanitising helper for the
// BCD counter family.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_DIGITS    = 3;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic logic [BCD_DIGIT_W-1:0] clamp_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_decrementor.sv
// One combinational BCD digit stage; chain en/borrow from ones digit upward.
module bcd_decrementor
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] in_i,
  input  logic                   en_i,
  output logic                   borrow_o,
  output logic [BCD_DIGIT_W-1:0] out_o
);

  always_comb begin
    out_o    = in_i;
    borrow_o = 1'b0;
    if (en_i) begin
      if (in_i == '0) begin
        out_o    = BCD_MAX_DIGIT;
        borrow_o = 1'b1;
      end else begin
        out_o = in_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter_12b.sv
// Loadable 3-digit packed-BCD countdown counter with start/pause control,
// terminal-count pulse and optional auto-reload.
module bcd_down_counter_12b
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        start,
  input  logic        pause,
  input  logic        tick,
  output logic [11:0] count,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        load_err
);

  localparam int unsigned CountW = BCD_DIGITS * BCD_DIGIT_W;

  state_e            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [CountW-1:0] reload_q, reload_d;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;

  logic [CountW-1:0]     load_clamped;
  logic                  load_bad;
  logic [CountW-1:0]     count_dec;
  logic [BCD_DIGITS-1:0] dig_en;
  logic [BCD_DIGITS-1:0] dig_borrow;
  logic                  count_empty;
  logic                  tick_ok;

  always_comb begin
    load_clamped = '0;
    load_bad     = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      load_clamped[i*BCD_DIGIT_W +: BCD_DIGIT_W] = clamp_digit(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
      if (load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        load_bad = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : gen_dig
    if (g == 0) begin : gen_first
      assign dig_en[g] = 1'b1;
    end else begin : gen_rest
      assign dig_en[g] = dig_borrow[g-1];
    end
    bcd_decrementor u_dec (
      .in_i     (count_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .en_i     (dig_en[g]),
      .borrow_o (dig_borrow[g]),
      .out_o    (count_dec[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A borrow out of the top digit happens only when every digit is 0.
  assign count_empty = dig_borrow[BCD_DIGITS-1];
  assign tick_ok     = (state_q == StRun) && tick && !pause;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_clamped;
      reload_d   = load_clamped;
      state_d    = StIdle;
      load_err_d = load_bad;
    end else if (start && (state_q == StIdle)) begin
      if (!count_empty) begin
        state_d = StRun;
      end
    end else if (tick_ok) begin
      if (count_empty) begin
        // Only reachable with auto-reload: the tick after terminal restarts the cycle.
        count_d = reload_q;
        if (reload_q == '0) begin
          state_d = StIdle;
        end
      end else begin
        count_d = count_dec;
        if (count_q == CountW'(1)) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) begin
            state_d = StIdle;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      reload_q   <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign zero     = (count_q == '0);
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter_12b.sv
// Table-driven scoreboard bench for bcd_down_counter_12b, covering both
// AUTO_RELOAD settings with two instances sharing one stimulus stream.
module tb_bcd_down_counter_12b;

  typedef struct {
    string       name;
    logic        rst;
    logic        ld;
    logic [11:0] lv;
    logic        st;
    logic        ps;
    logic        tk;
    logic        sel;
    logic [11:0] cnt;
    logic        busy;
    logic        done;
    logic        zero;
    logic        lerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, load, start, pause, tick;
  logic [11:0] load_val;
  logic [11:0] count0, count1;
  logic        busy0, busy1, done0, done1, zero0, zero1, lerr0, lerr1;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  bcd_down_counter_12b #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count0), .busy(busy0), .done(done0),
    .zero(zero0), .load_err(lerr0)
  );

  bcd_down_counter_12b #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count1), .busy(busy1), .done(done1),
    .zero(zero1), .load_err(lerr1)
  );

  function automatic void add(string name, logic rst, logic ld, logic [11:0] lv, logic st,
                              logic ps, logic tk, logic sel, logic [11:0] cnt, logic bsy,
                              logic dn, logic zr, logic le);
    vec_t v;
    v.name = name; v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.tk = tk;
    v.sel = sel; v.cnt = cnt; v.busy = bsy; v.done = dn; v.zero = zr; v.lerr = le;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, string field, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    reset = v.rst; load = v.ld; load_val = v.lv; start = v.st; pause = v.ps; tick = v.tk;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel) begin
      check(e.name, "count", int'(count1), int'(e.cnt));
      check(e.name, "busy", int'(busy1), int'(e.busy));
      check(e.name, "done", int'(done1), int'(e.done));
      check(e.name, "zero", int'(zero1), int'(e.zero));
      check(e.name, "load_err", int'(lerr1), int'(e.lerr));
    end else begin
      check(e.name, "count", int'(count0), int'(e.cnt));
      check(e.name, "busy", int'(busy0), int'(e.busy));
      check(e.name, "done", int'(done0), int'(e.done));
      check(e.name, "zero", int'(zero0), int'(e.zero));
      check(e.name, "load_err", int'(lerr0), int'(e.lerr));
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;

    //   name          rst ld  lv       st ps tk sel  cnt      bsy dn zr le
    add("reset",       1, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 0, 1, 0);
    add("start_zero",  0, 0, 12'h000, 1, 0, 1, 0, 12'h000, 0, 0, 1, 0);
    add("ld123",       0, 1, 12'h123, 0, 0, 0, 0, 12'h123, 0, 0, 0, 0);
    add("idle_tick",   0, 0, 12'h000, 0, 0, 1, 0, 12'h123, 0, 0, 0, 0);
    add("st123",       0, 0, 12'h000, 1, 0, 0, 0, 12'h123, 1, 0, 0, 0);
    add("t122",        0, 0, 12'h000, 0, 0, 1, 0, 12'h122, 1, 0, 0, 0);
    add("t121",        0, 0, 12'h000, 0, 0, 1, 0, 12'h121, 1, 0, 0, 0);
    add("t120",        0, 0, 12'h000, 1, 0, 1, 0, 12'h120, 1, 0, 0, 0);
    add("ld100",       0, 1, 12'h100, 0, 0, 0, 0, 12'h100, 0, 0, 0, 0);
    add("st100",       0, 0, 12'h000, 1, 0, 0, 0, 12'h100, 1, 0, 0, 0);
    add("t099",        0, 0, 12'h000, 0, 0, 1, 0, 12'h099, 1, 0, 0, 0);
    add("t098",        0, 0, 12'h000, 0, 0, 1, 0, 12'h098, 1, 0, 0, 0);
    add("ld002",       0, 1, 12'h002, 0, 0, 0, 0, 12'h002, 0, 0, 0, 0);
    add("st002",       0, 0, 12'h000, 1, 0, 0, 0, 12'h002, 1, 0, 0, 0);
    add("t001",        0, 0, 12'h000, 0, 0, 1, 0, 12'h001, 1, 0, 0, 0);
    add("t000",        0, 0, 12'h000, 0, 0, 1, 0, 12'h000, 0, 1, 1, 0);
    add("t000_again",  0, 0, 12'h000, 0, 0, 1, 0, 12'h000, 0, 0, 1, 0);
    add("ld5a9",       0, 1, 12'h5A9, 0, 0, 0, 0, 12'h599, 0, 0, 0, 1);
    add("lerr_clear",  0, 0, 12'h000, 0, 0, 0, 0, 12'h599, 0, 0, 0, 0);
    add("st599",       0, 0, 12'h000, 1, 0, 0, 0, 12'h599, 1, 0, 0, 0);
    add("pause1",      0, 0, 12'h000, 0, 1, 1, 0, 12'h599, 1, 0, 0, 0);
    add("pause2",      0, 0, 12'h000, 0, 1, 1, 0, 12'h599, 1, 0, 0, 0);
    add("pause3",      0, 0, 12'h000, 0, 1, 1, 0, 12'h599, 1, 0, 0, 0);
    add("pause4",      0, 0, 12'h000, 0, 1, 1, 0, 12'h599, 1, 0, 0, 0);
    add("unpause",     0, 0, 12'h000, 0, 0, 1, 0, 12'h598, 1, 0, 0, 0);
    add("ld_st_tk",    0, 1, 12'h456, 1, 0, 1, 0, 12'h456, 0, 0, 0, 0);
    add("ldF0F",       0, 1, 12'hF0F, 0, 0, 0, 0, 12'h909, 0, 0, 0, 1);
    add("st909",       0, 0, 12'h000, 1, 0, 0, 0, 12'h909, 1, 0, 0, 0);
    add("t908",        0, 0, 12'h000, 0, 0, 1, 0, 12'h908, 1, 0, 0, 0);
    add("rst_mid",     1, 0, 12'h000, 1, 0, 1, 0, 12'h000, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Auto-reload instance: terminal pulse, reload on next tick, second terminal pulse.
    tbl.delete();
    add("ar_reset",    1, 0, 12'h000, 0, 0, 0, 1, 12'h000, 0, 0, 1, 0);
    add("ar_ld001",    0, 1, 12'h001, 0, 0, 0, 1, 12'h001, 0, 0, 0, 0);
    add("ar_st",       0, 0, 12'h000, 1, 0, 0, 1, 12'h001, 1, 0, 0, 0);
    add("ar_t000",     0, 0, 12'h000, 0, 0, 1, 1, 12'h000, 1, 1, 1, 0);
    add("ar_reload",   0, 0, 12'h000, 0, 0, 1, 1, 12'h001, 1, 0, 0, 0);
    add("ar_t000b",    0, 0, 12'h000, 0, 0, 1, 1, 12'h000, 1, 1, 1, 0);
    add("ar_hold",     0, 0, 12'h000, 0, 0, 0, 1, 12'h000, 1, 0, 1, 0);
    add("ar_pause",    0, 0, 12'h000, 0, 1, 1, 1, 12'h000, 1, 0, 1, 0);
    add("ar_reload2",  0, 0, 12'h000, 0, 0, 1, 1, 12'h001, 1, 0, 0, 0);
    add("ar_ld_abort", 0, 1, 12'h210, 0, 0, 1, 1, 12'h210, 0, 0, 0, 0);
    add("ar_st210",    0, 0, 12'h000, 1, 0, 0, 1, 12'h210, 1, 0, 0, 0);
    add("ar_t209",     0, 0, 12'h000, 0, 0, 1, 1, 12'h209, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
